// File: rtl/line_fill_responder.sv
// line_fill_responder
// -------------------
// Turns one line-fill request from the instruction cache into
// N_CACHELINE_LENGTH single-word memory reads. Words are fetched in order
// 0..N-1 from the line-aligned base address. When every word has arrived,
// the whole line is presented to the cache.
//
// Ports
//   clk            single clock, rising edge
//   reset_i        asynchronous, active-high reset
//   req_valid_i    line-fill request from the cache
//   req_ready_o    block is idle and accepts a request
//   req_addr_i     byte address of any word within the wanted line
//   line_valid_o   assembled line is presented
//   line_ready_i   cache accepts the presented line
//   line_addr_o    line-aligned base byte address of the presented line
//   line_data_o    assembled line; word k at [BITSIZE*(k+1)-1 : BITSIZE*k]
//   mem_req_o      word read request to memory
//   mem_addr_o     byte address of the requested word
//   mem_gnt_i      memory accepted the current request
//   mem_rvalid_i   read data valid (earliest the cycle after grant)
//   mem_rdata_i    read data word
//   state_o        debug view of the FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RESP)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until that
// edge. The memory side follows the same rule: req is held with a stable
// address until gnt. Exactly one rvalid is expected per grant, and it
// arrives while the FSM waits for it.

module line_fill_responder #(
  parameter int N_CACHELINE_LENGTH = 4,
  parameter int BITSIZE            = 32
) (
  input  logic                                  clk,
  input  logic                                  reset_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [31:0]                           req_addr_i,
  output logic                                  line_valid_o,
  input  logic                                  line_ready_i,
  output logic [31:0]                           line_addr_o,
  output logic [BITSIZE*N_CACHELINE_LENGTH-1:0] line_data_o,
  output logic                                  mem_req_o,
  output logic [31:0]                           mem_addr_o,
  input  logic                                  mem_gnt_i,
  input  logic                                  mem_rvalid_i,
  input  logic [BITSIZE-1:0]                    mem_rdata_i,
  output logic [1:0]                            state_o
);

  localparam int LW   = BITSIZE * N_CACHELINE_LENGTH;
  localparam int CW   = $clog2(N_CACHELINE_LENGTH);
  localparam int OFFW = $clog2(N_CACHELINE_LENGTH * BITSIZE / 8);

  localparam logic [31:0]   WB32       = 32'(BITSIZE / 8);
  localparam logic [31:0]   ALIGN_MASK = ~((32'd1 << OFFW) - 32'd1);
  localparam logic [CW-1:0] LAST_WORD  = CW'(N_CACHELINE_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     base_q;
  logic [LW-1:0]   line_q;      // line under assembly
  logic [LW-1:0]   line_out_q;  // presented line, only updated on entry to RESP
  logic [31:0]     line_addr_q;
  logic            req_ready_q;
  logic            mem_req_q;
  logic [31:0]     mem_addr_q;
  logic            line_valid_q;

  logic [LW-1:0]   line_d;
  logic [31:0]     aligned_addr;
  logic [31:0]     next_word_addr;

  assign aligned_addr   = req_addr_i & ALIGN_MASK;
  assign next_word_addr = base_q + (32'(cnt_q) + 32'd1) * WB32;

  // Assembly buffer with the incoming word dropped into slot cnt_q.
  always_comb begin
    line_d = line_q;
    for (int k = 0; k < N_CACHELINE_LENGTH; k++) begin
      if (cnt_q == CW'(k)) begin
        line_d[k*BITSIZE +: BITSIZE] = mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      line_q       <= '0;
      line_out_q   <= '0;
      line_addr_q  <= '0;
      req_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      line_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            base_q      <= aligned_addr;
            cnt_q       <= '0;
            line_q      <= '0;
            req_ready_q <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= aligned_addr;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            line_q <= line_d;
            if (cnt_q == LAST_WORD) begin
              // The output copy is loaded once, so the presented line and
              // address keep their values after the cache takes them.
              line_out_q   <= line_d;
              line_addr_q  <= base_q;
              line_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              mem_req_q  <= 1'b1;
              mem_addr_q <= next_word_addr;
              state_q    <= REQ;
            end
          end
        end
        RESP: begin
          // req_ready rises only after this edge, so a new request cannot
          // be taken in the same cycle that the line leaves.
          if (line_ready_i) begin
            line_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign line_valid_o = line_valid_q;
  assign line_addr_o  = line_addr_q;
  assign line_data_o  = line_out_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_line_fill_responder.sv
module tb_line_fill_responder;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LW = N * W;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [31:0]   req_addr_i;
  logic          line_valid_o;
  logic          line_ready_i;
  logic [31:0]   line_addr_o;
  logic [LW-1:0] line_data_o;
  logic          mem_req_o;
  logic [31:0]   mem_addr_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [W-1:0]  mem_rdata_i;
  logic [1:0]    state_o;

  line_fill_responder #(.N_CACHELINE_LENGTH(N), .BITSIZE(W)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .line_valid_o (line_valid_o),
    .line_ready_i (line_ready_i),
    .line_addr_o  (line_addr_o),
    .line_data_o  (line_data_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .state_o      (state_o)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // scoreboard
  logic [31:0]   exp_maddr_q[$];
  logic [31:0]   exp_laddr_q[$];
  logic [LW-1:0] exp_line_q[$];

  // memory model knobs and state
  logic [31:0] mem_base_data = 32'h0;
  int          gnt_delay_word = 0;
  int          gnt_delay = 0;
  int          wait_cnt = 0;
  int          stall_cnt = 0;
  int          gnt_cnt = 0;
  bit          rvalid_pend = 0;
  bit          rvalid_block = 0;
  bit          stray_rvalid = 0;
  logic [31:0] pend_data = 32'h0;
  int          line_hs_cnt = 0;
  int          line_hs_cyc = -10;
  int          req_hs_cyc = -10;

  // One cycle: answer memory, check and record handshakes for the coming
  // edge, then advance to the next falling edge.
  task automatic step();
    logic [31:0]   base;
    logic [LW-1:0] ld;
    logic [31:0]   ea;
    logic [LW-1:0] el;
    int            widx;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (stray_rvalid) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEADBEEF;
      stray_rvalid = 0;
    end else if (rvalid_pend && !rvalid_block) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = pend_data;
      rvalid_pend  = 0;
    end
    if (mem_req_o) begin
      ea = (exp_maddr_q.size() != 0) ? exp_maddr_q[0] : 32'hFFFF_FFFF;
      total++;
      if (mem_addr_o !== ea) begin
        bad++;
        $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr_o, ea);
      end
      widx = int'((mem_addr_o >> 2) % N);
      if (wait_cnt >= ((widx == gnt_delay_word) ? gnt_delay : 0)) begin
        mem_gnt_i = 1'b1;
        if (exp_maddr_q.size() != 0) void'(exp_maddr_q.pop_front());
        pend_data   = mem_base_data + 32'(widx);
        rvalid_pend = 1;
        wait_cnt    = 0;
        gnt_cnt++;
      end else begin
        wait_cnt++;
        stall_cnt++;
      end
    end else begin
      total++;
      if (mem_addr_o !== 32'h0) begin
        bad++;
        $display("FAIL mem_addr_idle cyc=%0d got=%h exp=0", cyc, mem_addr_o);
      end
    end
    if (line_valid_o && line_ready_i) begin
      ea = (exp_laddr_q.size() != 0) ? exp_laddr_q.pop_front() : 32'hFFFF_FFFF;
      el = (exp_line_q.size() != 0) ? exp_line_q.pop_front() : '1;
      total++;
      if (line_addr_o !== ea) begin
        bad++;
        $display("FAIL line_addr got=%h exp=%h", line_addr_o, ea);
      end
      total++;
      if (line_data_o !== el) begin
        bad++;
        $display("FAIL line_data got=%h exp=%h", line_data_o, el);
      end
      line_hs_cnt++;
      line_hs_cyc = cyc;
    end
    if (req_valid_i && req_ready_o) begin
      base = req_addr_i & ~32'(N * 4 - 1);
      ld   = '0;
      for (int k = 0; k < N; k++) begin
        exp_maddr_q.push_back(base + 32'(4 * k));
        ld[k*W +: W] = mem_base_data + 32'(k);
      end
      exp_laddr_q.push_back(base);
      exp_line_q.push_back(ld);
      req_hs_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_line(input int budget);
    int start;
    int n;
    start = line_hs_cnt;
    n = 0;
    while (line_hs_cnt == start && n < budget) begin
      step();
      n++;
    end
    total++;
    if (line_hs_cnt == start) begin
      bad++;
      $display("FAIL line_timeout got=none exp=line within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({req_ready_o, line_valid_o, mem_req_o, state_o} !== 5'b1_0_0_00) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=10000", {req_ready_o, line_valid_o, mem_req_o, state_o});
    end
    total++;
    if (mem_addr_o !== 32'h0 || line_addr_o !== 32'h0 || line_data_o !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", mem_addr_o, line_addr_o, line_data_o);
    end
    reset_i = 1'b0;
    step();
  endtask

  // Zero-wait memory; line_valid in cycle 1+2N counting the handshake cycle as 1.
  task automatic test_basic();
    int edges;
    logic [LW-1:0] exp_line;
    exp_line = 128'h000000A3_000000A2_000000A1_000000A0;
    mem_base_data = 32'hA0;
    gnt_delay = 0;
    line_ready_i = 1'b1;
    req_addr_i = 32'h0000_104C;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    edges = 1;
    while (!line_valid_o && edges < 40) begin
      step();
      edges++;
    end
    total++;
    if (edges !== 1 + 2 * N) begin
      bad++;
      $display("FAIL latency got=%0d exp=%0d", edges, 1 + 2 * N);
    end
    total++;
    if (line_addr_o !== 32'h0000_1040 || line_data_o !== exp_line) begin
      bad++;
      $display("FAIL basic_line got=%h/%h exp=%h/%h", line_addr_o, line_data_o, 32'h1040, exp_line);
    end
    step();
    total++;
    if (req_ready_o !== 1'b1 || line_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle got=%b%b exp=10", req_ready_o, line_valid_o);
    end
  endtask

  task automatic test_grant_delay();
    stall_cnt = 0;
    gnt_delay_word = 2;
    gnt_delay = 3;
    mem_base_data = 32'h5500_0010;
    line_ready_i = 1'b1;
    req_addr_i = 32'h0000_0204;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    wait_line(60);
    total++;
    if (stall_cnt !== 3) begin
      bad++;
      $display("FAIL grant_stall got=%0d exp=3", stall_cnt);
    end
    gnt_delay = 0;
  endtask

  task automatic test_backpressure();
    logic [LW-1:0] el;
    int n;
    for (int k = 0; k < N; k++) el[k*W +: W] = 32'h7777_0000 + 32'(k);
    mem_base_data = 32'h7777_0000;
    line_ready_i = 1'b0;
    req_addr_i = 32'h0000_5008;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    n = 0;
    while (!line_valid_o && n < 40) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      req_valid_i = 1'b1;
      req_addr_i = 32'h0000_9000;
      total++;
      if (line_valid_o !== 1'b1 || req_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL bp_ctrl i=%0d got=%b%b exp=10", i, line_valid_o, req_ready_o);
      end
      total++;
      if (line_addr_o !== 32'h0000_5000 || line_data_o !== el) begin
        bad++;
        $display("FAIL bp_hold i=%0d got=%h/%h exp=%h/%h", i, line_addr_o, line_data_o, 32'h5000, el);
      end
      step();
    end
    req_valid_i = 1'b0;
    line_ready_i = 1'b1;
    step();
    total++;
    if (req_ready_o !== 1'b1 || line_valid_o !== 1'b0 || line_addr_o !== 32'h0000_5000) begin
      bad++;
      $display("FAIL bp_after got=%b%b/%h exp=10/00005000", req_ready_o, line_valid_o, line_addr_o);
    end
    total++;
    if (exp_line_q.size() !== 0) begin
      bad++;
      $display("FAIL bp_extra got=%0d exp=0", exp_line_q.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    int start;
    int n;
    mem_base_data = 32'h1;
    line_ready_i = 1'b1;
    req_addr_i = 32'h0000_6000;
    req_valid_i = 1'b1;
    start = gnt_cnt;
    step();
    req_valid_i = 1'b0;
    n = 0;
    while (gnt_cnt < start + 2 && n < 40) begin
      step();
      n++;
    end
    rvalid_block = 1;
    total++;
    if (state_o !== 2'd2) begin
      bad++;
      $display("FAIL mid_state got=%0d exp=2", state_o);
    end
    #2 reset_i = 1'b1;
    #1;
    total++;
    if ({req_ready_o, line_valid_o, mem_req_o, state_o} !== 5'b1_0_0_00) begin
      bad++;
      $display("FAIL async_ctrl got=%b exp=10000", {req_ready_o, line_valid_o, mem_req_o, state_o});
    end
    total++;
    if (mem_addr_o !== 32'h0 || line_addr_o !== 32'h0 || line_data_o !== '0) begin
      bad++;
      $display("FAIL async_data got=%h/%h/%h exp=0", mem_addr_o, line_addr_o, line_data_o);
    end
    @(negedge clk);
    reset_i = 1'b0;
    exp_maddr_q.delete();
    exp_laddr_q.delete();
    exp_line_q.delete();
    rvalid_pend = 0;
    rvalid_block = 0;
    wait_cnt = 0;
    stray_rvalid = 1;
    step();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (state_o !== 2'd0 || req_ready_o !== 1'b1 || mem_req_o !== 1'b0 || line_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL stray_rvalid i=%0d got=%0d%b%b%b exp=0100", i, state_o, req_ready_o, mem_req_o, line_valid_o);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    mem_base_data = 32'hB0;
    line_ready_i = 1'b1;
    req_addr_i = 32'h0000_2000;
    req_valid_i = 1'b1;
    step();
    req_addr_i = 32'h0000_3010;
    wait_line(60);
    step();
    total++;
    if (req_hs_cyc !== line_hs_cyc + 1) begin
      bad++;
      $display("FAIL b2b_accept got=%0d exp=%0d", req_hs_cyc, line_hs_cyc + 1);
    end
    req_valid_i = 1'b0;
    wait_line(60);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      mem_base_data = $urandom;
      gnt_delay_word = $urandom_range(0, N - 1);
      gnt_delay = $urandom_range(0, 2);
      line_ready_i = 1'b1;
      req_addr_i = $urandom;
      req_valid_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      wait_line(80);
    end
    gnt_delay = 0;
  endtask

  initial begin
    reset_i = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i = '0;
    line_ready_i = 1'b0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_grant_delay();
    test_backpressure();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    total++;
    if (exp_line_q.size() !== 0 || exp_maddr_q.size() !== 0) begin
      bad++;
      $display("FAIL leftover got=%0d/%0d exp=0/0", exp_line_q.size(), exp_maddr_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_fill_responder.md
LINE_FILL_RESPONDER -- requirements
Module: line_fill_responder

Interface
REQ-001 Parameter N_CACHELINE_LENGTH, default 4, SHALL be the number of words per cache line (power of two, >=2).
REQ-002 Parameter BITSIZE, default 32, SHALL be the word width in bits (multiple of 8).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset_i  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req_valid_i  input  1  SHALL mark a line-fill request from the instruction cache.
REQ-006 req_ready_o  output  1  SHALL mark that the block accepts a request.
REQ-007 req_addr_i  input  32  SHALL be the byte address of any word within the requested line.
REQ-008 line_valid_o  output  1  SHALL mark that an assembled line is presented.
REQ-009 line_ready_i  input  1  SHALL mark that the cache accepts the presented line.
REQ-010 line_addr_o  output  32  SHALL be the line-aligned base byte address of the presented line.
REQ-011 line_data_o  output  BITSIZE*N_CACHELINE_LENGTH  SHALL be the assembled line; word k at bits [BITSIZE*(k+1)-1 : BITSIZE*k].
REQ-012 mem_req_o  output  1  SHALL mark a word read request to memory.
REQ-013 mem_addr_o  output  32  SHALL be the word read byte address.
REQ-014 mem_gnt_i  input  1  SHALL mark that memory accepted the current request.
REQ-015 mem_rvalid_i  input  1  SHALL mark valid read data.
REQ-016 mem_rdata_i  input  BITSIZE  SHALL be the read data word.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, RESP; word counter cnt width $clog2(N_CACHELINE_LENGTH).
REQ-018 req_ready_o SHALL be 1 exactly in IDLE; handshake occurs when req_valid_i && req_ready_o at a rising edge.
REQ-019 On handshake: base <= req_addr_i with low $clog2(N_CACHELINE_LENGTH*BITSIZE/8) bits cleared; cnt <= 0; line_data register <= 0; IDLE -> REQ.
REQ-020 In REQ: mem_req_o = 1, mem_addr_o = base + cnt*(BITSIZE/8); on mem_gnt_i -> WAIT; mem_req_o/mem_addr_o SHALL stay stable until grant.
REQ-021 mem_req_o SHALL be 0 in all states other than REQ; mem_addr_o SHALL be 0 outside REQ.
REQ-022 In WAIT: on mem_rvalid_i, word slot cnt <= mem_rdata_i; if cnt == N_CACHELINE_LENGTH-1 -> RESP, else cnt <= cnt+1 and -> REQ.
REQ-023 mem_rvalid_i SHALL be ignored in IDLE, REQ and RESP (earliest valid response is the cycle after grant).
REQ-024 Word fetch order SHALL be 0..N-1 regardless of the word offset of req_addr_i; addresses never cross the line boundary.
REQ-025 In RESP: line_valid_o = 1, line_addr_o = base, line_data_o held stable until line_ready_i; on line_valid_o && line_ready_i -> IDLE.
REQ-026 line_valid_o SHALL be 0 outside RESP; line_addr_o and line_data_o hold their last values outside RESP.
REQ-027 Minimum request-to-line_valid_o latency with zero-wait memory (grant in first REQ cycle, rvalid in next cycle) SHALL be 1 + 2*N_CACHELINE_LENGTH cycles.
REQ-028 A new request SHALL NOT be accepted in the cycle RESP completes; next acceptance is the following cycle at earliest.

Reset
REQ-029 reset_i high SHALL immediately force state IDLE, cnt 0, base 0, line_data 0, line_valid_o 0, mem_req_o 0, mem_addr_o 0, line_addr_o 0, line_data_o 0, req_ready_o 1.
REQ-030 Reset mid-fill SHALL abandon the fill; any outstanding mem_rvalid_i after release SHALL be ignored (state IDLE).

Verification
REQ-031 Zero-wait memory, N=4, req_addr_i=0x0000_104C, words 0xA0..0xA3 -> mem_addr_o 0x1040,0x1044,0x1048,0x104C; line_addr_o=0x1040, line_data_o=0x000000A3_000000A2_000000A1_000000A0; line_valid_o at cycle 9 after handshake.
REQ-032 Grant delayed 3 cycles on word 2 -> mem_req_o and mem_addr_o=0x1048 held stable for all 4 cycles, single rvalid captured into slot 2.
REQ-033 line_ready_i low 5 cycles in RESP -> line_valid_o, line_addr_o, line_data_o stable 5 cycles; req_ready_o 0 throughout; req_valid_i meanwhile not accepted.
REQ-034 reset_i pulsed while in WAIT for word 1 -> all outputs to REQ-029 values asynchronously; a stray mem_rvalid_i after release produces no state change.
REQ-035 Back-to-back requests 0x2000 and 0x3010 with req_valid_i held -> second accepted the cycle after the first's line_valid_o/line_ready_i handshake; line_addr_o 0x2000 then 0x3010.
